stepdown_pwm_seq: RTL

STEPDOWN_PWM_SEQ -- requirements
Module: stepdown_pwm_seq

---
 rtl/stepdown_pkg.sv | 26 ++
 rtl/stepdown_sync2.sv | 26 ++
 rtl/stepdown_pwm_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/stepdown_pkg.sv
// stepdown_pkg: shared FSM state encoding, default parameter values and a
// small decode helper for the step-down PWM sequencer.
package stepdown_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_BLANK = 3'd2,
    ST_ON    = 3'd3,
    ST_OFF   = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_PERIOD   = 200;
  localparam int DEF_BLANK    = 6;
  localparam int DEF_TON_MIN  = 10;
  localparam int DEF_TON_MAX  = 180;
  localparam int DEF_TOFF_MIN = 8;

  // The latch reset line is held in every state where the switch must be off.
  function automatic logic st_holds_reset(input state_t st);
    return (st == ST_IDLE) || (st == ST_OFF) || (st == ST_FAULT);
  endfunction

endpackage

// File: rtl/stepdown_sync2.sv
// stepdown_sync2: two-flop synchronizer for asynchronous single-bit inputs.
// Output lags the input by two rising edges of clk; both flops clear on reset.
module stepdown_sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/stepdown_pwm_seq.sv
// stepdown_pwm_seq: peak-current-mode PWM sequencer driving an external SR
// latch (s / r / rb). One set per switching period at pcnt==0, leading-edge
// blanking, min/max on-time, min off-time and a latched overcurrent fault.
// Optional feature macro: STEPDOWN_SKIP_EN adds a synchronized 'skip' input
// that suppresses the set of a period (light-load pulse skipping).
// Handshake note: there is no valid/ready traffic here; en is a level-sensitive
// synchronous enable and comp/ocp/skip are asynchronous levels that are only
// acted upon after the two-flop synchronizers.
module stepdown_pwm_seq
  import stepdown_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int BLANK    = DEF_BLANK,
  parameter int TON_MIN  = DEF_TON_MIN,
  parameter int TON_MAX  = DEF_TON_MAX,
  parameter int TOFF_MIN = DEF_TOFF_MIN
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  logic       comp,
  input  logic       ocp,
`ifdef STEPDOWN_SKIP_EN
  input  logic       skip,
`endif
  output logic       s,
  output logic       r,
  output logic       rb,
  output logic       fault,
  output logic       cyc_start,
  output logic [2:0] dbg_state
);

  localparam logic [CNT_W-1:0] LP_PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LP_BLANK     = CNT_W'(BLANK);
  localparam logic [CNT_W-1:0] LP_TON_MIN   = CNT_W'(TON_MIN);
  localparam logic [CNT_W-1:0] LP_TON_MAX_M1 = CNT_W'(TON_MAX - 1);
  localparam logic [CNT_W-1:0] LP_TOFF_MIN  = CNT_W'(TOFF_MIN);
  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_ton;
  logic [CNT_W-1:0] r_toff;

  logic w_comp_s;
  logic w_ocp_s;
  logic w_skip_gate;

  logic w_s_d;
  logic w_r_d;
  logic w_fault_d;

  logic r_s;
  logic r_r;
  logic r_rb;
  logic r_fault;
  logic r_cyc_start;

  stepdown_sync2 u_sync_comp (
    .clk  (clk),
    .rstb (rstb),
    .d    (comp),
    .q    (w_comp_s)
  );

  stepdown_sync2 u_sync_ocp (
    .clk  (clk),
    .rstb (rstb),
    .d    (ocp),
    .q    (w_ocp_s)
  );

`ifdef STEPDOWN_SKIP_EN
  logic w_skip_s;

  stepdown_sync2 u_sync_skip (
    .clk  (clk),
    .rstb (rstb),
    .d    (skip),
    .q    (w_skip_s)
  );

  assign w_skip_gate = w_skip_s;
`else
  assign w_skip_gate = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a synchronized overcurrent overrides everything else.
  always_comb begin
    w_next = r_state;
    if (w_ocp_s) begin
      w_next = ST_FAULT;
    end else if (r_state == ST_FAULT) begin
      if (!en) w_next = ST_IDLE;
    end else if (!en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_OFF;
        ST_OFF:   if ((r_pcnt == '0) && (r_toff >= LP_TOFF_MIN) && !w_skip_gate)
                    w_next = ST_SET;
        ST_SET:   w_next = ST_BLANK;
        ST_BLANK: if (r_ton == LP_BLANK) w_next = ST_ON;
        ST_ON:    if ((w_comp_s && (r_ton >= LP_TON_MIN)) || (r_ton == LP_TON_MAX_M1))
                    w_next = ST_OFF;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    w_s_d     = (w_next == ST_SET);
    w_r_d     = st_holds_reset(w_next);
    w_fault_d = (w_next == ST_FAULT);
  end

  // Output registers; reset forces the latch reset line high immediately.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_s         <= 1'b0;
      r_r         <= 1'b1;
      r_rb        <= 1'b0;
      r_fault     <= 1'b0;
      r_cyc_start <= 1'b0;
    end else begin
      r_s         <= w_s_d;
      r_r         <= w_r_d;
      r_rb        <= ~w_r_d;
      r_fault     <= w_fault_d;
      r_cyc_start <= w_s_d;
    end
  end

  // Period, on-time and off-time counters.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_pcnt <= '0;
      r_ton  <= '0;
      r_toff <= '0;
    end else begin
      if (!en || (r_state == ST_FAULT)) begin
        r_pcnt <= '0;
      end else if (r_pcnt == LP_PERIOD_M1) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + LP_ONE;
      end

      // On-time is 0 in SET and counts up through BLANK and ON.
      if ((w_next == ST_BLANK) || (w_next == ST_ON)) begin
        r_ton <= r_ton + LP_ONE;
      end else begin
        r_ton <= '0;
      end

      // Off-time counts clocks spent in OFF, saturating.
      if (r_state == ST_OFF) begin
        if (r_toff != '1) r_toff <= r_toff + LP_ONE;
      end else begin
        r_toff <= '0;
      end
    end
  end

  assign s         = r_s;
  assign r         = r_r;
  assign rb        = r_rb;
  assign fault     = r_fault;
  assign cyc_start = r_cyc_start;
  assign dbg_state = r_state;

endmodule
